// File: rtl/vga_sync_decoder.sv
// Sink-side VGA timing decoder: rebuilds pixel X/Y from HS/VS, checks line/frame timing, tracks lock.
// Define FRAME_CRC_EN to add frame_crc/crc_valid (CRC-16-CCITT over each locked frame's pixels).
module vga_sync_decoder #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [1:0] color_in,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       pixel_valid,
    output logic [1:0] color_out,
    output logic       frame_start,
    output logic       locked,
    output logic       h_error,
    output logic       v_error,
    output logic [3:0] lock_loss_count
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [9:0] L_H_LAST = 10'(H_SYNC + H_BP + H_VISIBLE + H_FP - 1);
    localparam logic [9:0] L_H_SYNC = 10'(H_SYNC);
    localparam logic [9:0] L_X0     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] L_X1     = 10'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [9:0] L_V_LAST = 10'(V_SYNC + V_BP + V_VISIBLE + V_FP - 1);
    localparam logic [9:0] L_V_SYNC = 10'(V_SYNC);
    localparam logic [9:0] L_Y0     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] L_Y1     = 10'(V_SYNC + V_BP + V_VISIBLE - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     r_state;
    logic       r_hs_q, r_vs_line, r_h_seen, r_v_seen, r_align_bad;
    logic [9:0] r_h_cnt, r_v_cnt;
    logic [9:0] r_x_pos, r_y_pos;
    logic [1:0] r_color_out;
    logic       r_pixel_valid, r_frame_start, r_locked, r_h_error, r_v_error;
    logic [3:0] r_lock_loss;

    logic       w_line_start, w_hs_rise, w_frame_start;
    logic       w_h_err, w_v_err, w_visible;
    logic [9:0] w_h_cnt, w_v_cnt;

    // Counts describe the current cycle: the line-start cycle itself is h_cnt 0.
    assign w_line_start  = r_hs_q & ~vga_hs;
    assign w_hs_rise     = ~r_hs_q & vga_hs;
    assign w_frame_start = w_line_start & ~vga_vs & r_vs_line;

    always_comb begin
        w_h_cnt = (r_h_cnt == '1) ? r_h_cnt : r_h_cnt + 10'd1;
        if (w_line_start)
            w_h_cnt = '0;
        w_v_cnt = r_v_cnt;
        if (w_frame_start)
            w_v_cnt = '0;
        else if (w_line_start && r_v_cnt != '1)
            w_v_cnt = r_v_cnt + 10'd1;
    end

    assign w_h_err = r_h_seen & ((w_line_start & (r_h_cnt != L_H_LAST)) |
                                 (w_hs_rise & (w_h_cnt != L_H_SYNC)));
    assign w_v_err = r_v_seen & ((w_frame_start & (r_v_cnt != L_V_LAST)) |
                                 (w_line_start & vga_vs & (w_v_cnt < L_V_SYNC)));
    assign w_visible = (w_h_cnt >= L_X0) && (w_h_cnt <= L_X1) &&
                       (w_v_cnt >= L_Y0) && (w_v_cnt <= L_Y1);

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_state       <= SEARCH;
            r_hs_q        <= 1'b1;
            r_vs_line     <= 1'b1;
            r_h_seen      <= 1'b0;
            r_v_seen      <= 1'b0;
            r_align_bad   <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_color_out   <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_h_error     <= 1'b0;
            r_v_error     <= 1'b0;
            r_lock_loss   <= '0;
        end else begin
            r_hs_q        <= vga_hs;
            r_h_cnt       <= w_h_cnt;
            r_v_cnt       <= w_v_cnt;
            r_h_error     <= w_h_err;
            r_v_error     <= w_v_err;
            r_frame_start <= w_frame_start;
            r_pixel_valid <= w_visible & (r_state == LOCKED);
            if (w_line_start) begin
                r_h_seen  <= 1'b1;
                r_vs_line <= vga_vs;
            end
            if (w_frame_start)
                r_v_seen <= 1'b1;
            if (w_visible) begin
                r_x_pos     <= w_h_cnt - L_X0;
                r_y_pos     <= w_v_cnt - L_Y0;
                r_color_out <= color_in;
            end
            case (r_state)
                SEARCH: begin
                    if (w_frame_start) begin
                        r_state     <= ALIGN;
                        r_align_bad <= 1'b0;
                    end
                end
                ALIGN: begin
                    // A bad alignment frame restarts the check from this frame start.
                    if (w_frame_start) begin
                        r_align_bad <= 1'b0;
                        if (!(r_align_bad | w_h_err | w_v_err)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_h_err | w_v_err) begin
                        r_align_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_h_err | w_v_err) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        if (r_lock_loss != '1)
                            r_lock_loss <= r_lock_loss + 4'd1;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign x_pos           = r_x_pos;
    assign y_pos           = r_y_pos;
    assign pixel_valid     = r_pixel_valid;
    assign color_out       = r_color_out;
    assign frame_start     = r_frame_start;
    assign locked          = r_locked;
    assign h_error         = r_h_error;
    assign v_error         = r_v_error;
    assign lock_loss_count = r_lock_loss;

`ifdef FRAME_CRC_EN
    logic [15:0] r_crc_acc, r_frame_crc;
    logic        r_crc_valid;

    function automatic logic [15:0] f_crc_2b(input logic [15:0] c, input logic [1:0] d);
        logic [15:0] v;
        v = {c[14:0], 1'b0} ^ ((c[15] ^ d[1]) ? 16'h1021 : 16'h0000);
        v = {v[14:0], 1'b0} ^ ((v[15] ^ d[0]) ? 16'h1021 : 16'h0000);
        return v;
    endfunction

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_crc_acc   <= '1;
            r_frame_crc <= '0;
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            if (w_frame_start) begin
                if (r_state == LOCKED) begin
                    r_frame_crc <= r_crc_acc;
                    r_crc_valid <= 1'b1;
                end
                r_crc_acc <= '1;
            end else if (r_pixel_valid) begin
                r_crc_acc <= f_crc_2b(r_crc_acc, r_color_out);
            end
        end
    end

    assign frame_crc = r_frame_crc;
    assign crc_valid = r_crc_valid;
`endif

endmodule
